mem_access_unit: RTL and testbench

- Sits directly upstream of the word-indexed data memory in the MEM stage of the pipeline.
- Converts byte-addressed load/store requests (byte, half, word; signed/unsigned) from the EX/MEM register into memory read_write/address/data commands.
- Performs read-modify-write for sub-word stores and lane-extracts loads into a registered result for MEM/WB.
- Stalls the pipeline for one cycle on each sub-word store.

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/byte_lane_unit.sv | 47 ++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and alignment helper for the MEM-stage access unit
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_e;

    // Truncate low address bits to the natural alignment of the access size.
    function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [1:0] size);
        logic [1:0] res;
        case (size)
            SZ_BYTE: res = lo;
            SZ_HALF: res = {lo[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - little-endian lane extraction/extension for loads and lane merge for stores
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shift_amt;
    logic [31:0] shifted;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign shift_amt = {lane, 3'b000};
    assign shifted   = word >> shift_amt;
    assign lane_byte = shifted[7:0];
    assign lane_half = shifted[15:0];

    always_comb begin
        load_data = '0;
        merged    = word;
        case (size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {24'b0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                merged[shift_amt +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {16'b0, lane_half} : {{16{lane_half[15]}}, lane_half};
                merged[shift_amt +: 16] = store_data[15:0];
            end
            SZ_WORD: begin
                load_data = word;
                merged    = store_data;
            end
            default: begin
                load_data = '0;
                merged    = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store to word-memory adapter with sub-word RMW; MISALIGN_TRAP_EN traps misaligned half/word
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [1:0]    in_size,
    input  logic          in_unsigned,
    input  logic [AW-1:0] in_byte_addr,
    input  logic [31:0]   in_store_data,
    output logic [1:0]    mem_read_write,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_read_data,
    output logic          stall,
    output logic          out_valid,
    output logic [31:0]   out_load_data,
    output logic          out_error
);

    state_e        state, state_next;
    logic [31:0]   merge_buf;
    logic [AW-1:0] word_index;
    logic          active, is_read, is_write, both_rw;
    logic          out_of_range, illegal_size, misaligned, req_error;
    logic [1:0]    lane;
    logic [31:0]   lane_word, lane_load, lane_merged;
    logic          valid_next, error_next, merge_load;
    logic [31:0]   load_next;

    assign word_index   = in_byte_addr >> 2;
    assign mem_address  = word_index;
    assign active       = in_valid & (in_mem_read | in_mem_write);
    assign is_read      = in_mem_read & ~in_mem_write;
    assign is_write     = in_mem_write & ~in_mem_read;
    assign both_rw      = in_mem_read & in_mem_write;
    assign out_of_range = (word_index >= AW'(DEPTH));
    assign illegal_size = (in_size == SZ_ILLEGAL);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((in_size == SZ_HALF) && in_byte_addr[0]) ||
                        ((in_size == SZ_WORD) && (in_byte_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_error = out_of_range | illegal_size | both_rw | misaligned;
    assign lane      = align_lo(in_byte_addr[1:0], in_size);

    // The merge buffer feeds the lane unit only while the RMW write is in flight.
    assign lane_word = (state == RMW_WRITE) ? merge_buf : mem_read_data;

    byte_lane_unit u_lanes (
        .word        (lane_word),
        .lane        (lane),
        .size        (in_size),
        .is_unsigned (in_unsigned),
        .store_data  (in_store_data),
        .load_data   (lane_load),
        .merged      (lane_merged)
    );

    always_comb begin
        state_next     = state;
        mem_read_write = RW_IDLE;
        mem_write_data = '0;
        stall          = 1'b0;
        valid_next     = 1'b0;
        load_next      = '0;
        error_next     = 1'b0;
        merge_load     = 1'b0;
        case (state)
            IDLE: begin
                if (active) begin
                    if (req_error) begin
                        valid_next = 1'b1;
                        error_next = 1'b1;
                    end else if (is_read) begin
                        mem_read_write = RW_READ;
                        valid_next     = 1'b1;
                        load_next      = lane_load;
                    end else if (is_write && (in_size == SZ_WORD)) begin
                        mem_read_write = RW_WRITE;
                        mem_write_data = lane_merged;
                        valid_next     = 1'b1;
                    end else if (is_write) begin
                        mem_read_write = RW_READ;
                        stall          = 1'b1;
                        merge_load     = 1'b1;
                        state_next     = RMW_WRITE;
                    end
                end
            end
            RMW_WRITE: begin
                mem_read_write = RW_WRITE;
                mem_write_data = lane_merged;
                valid_next     = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Memory must see no command while reset is asserted, even mid-RMW.
        if (!rst) begin
            mem_read_write = RW_IDLE;
            stall          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            out_valid     <= 1'b0;
            out_load_data <= '0;
            out_error     <= 1'b0;
            merge_buf     <= '0;
        end else begin
            state         <= state_next;
            out_valid     <= valid_next;
            out_load_data <= load_next;
            out_error     <= error_next;
            if (merge_load) begin
                merge_buf <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit with a negedge-write word memory model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic        in_unsigned = 1'b0;
    logic [31:0] in_byte_addr = '0;
    logic [31:0] in_store_data = '0;
    logic [1:0]  mem_read_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_load_data;
    logic        out_error;

    int vectors = 0;
    int errs    = 0;
    int wr_cnt  = 0;
    logic [32:0] sb_q [$];

    logic [31:0] mem [10] = '{32'hCAFE1234, 32'h11223344, 32'h0, 32'h00000104, 32'h0,
                              32'h0, 32'h00000107, 32'h0, 32'h0, 32'h0};

    mem_access_unit #(.DEPTH(10), .AW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_size        (in_size),
        .in_unsigned    (in_unsigned),
        .in_byte_addr   (in_byte_addr),
        .in_store_data  (in_store_data),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_load_data  (out_load_data),
        .out_error      (out_error)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < 32'd10) ? mem[mem_address[3:0]] : 32'h0;

    always @(negedge clk) begin
        if (mem_read_write == 2'b01) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_address < 32'd10) mem[mem_address[3:0]] <= mem_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [1:0] exp_rw, input logic exp_stall, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_load, input logic exp_err);
        logic [32:0] e;
        @(posedge clk); #1;
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_size = sz;
        in_unsigned = uns; in_byte_addr = addr; in_store_data = sdata;
        sb_q.push_back({exp_err, exp_load});
        #1;
        chk({tag, " rw"}, 32'(mem_read_write), 32'(exp_rw));
        chk({tag, " stall"}, 32'(stall), 32'(exp_stall));
        if (exp_stall) begin
            @(posedge clk); #1;
            chk({tag, " rmw rw"}, 32'(mem_read_write), 32'(2'b01));
            chk({tag, " rmw stall"}, 32'(stall), 32'(1'b0));
            chk({tag, " rmw wdata"}, mem_write_data, exp_wdata);
        end else if (exp_rw == 2'b01) begin
            chk({tag, " wdata"}, mem_write_data, exp_wdata);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(1'b1));
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'(1), 32'(0));
        end else begin
            e = sb_q.pop_front();
            chk({tag, " load"}, out_load_data, e[31:0]);
            chk({tag, " error"}, 32'(out_error), 32'(e[32]));
        end
    endtask

    initial begin
        int wr_before;
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_before;
        // reset state, with a load request presented during reset
        in_valid = 1'b1; in_mem_read = 1'b1; in_size = 2'b10; in_byte_addr = 32'd12;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rw", 32'(mem_read_write), 32'(2'b00));
        chk("reset out_valid", 32'(out_valid), 32'(1'b0));
        chk("reset load", out_load_data, 32'h0);
        chk("reset error", 32'(out_error), 32'(1'b0));
        in_valid = 1'b0; in_mem_read = 1'b0;
        rst = 1'b1;

        issue("lb12", 1, 0, 2'b00, 0, 32'd12, 0, 2'b10, 0, 0, 32'h00000004, 0);
        issue("lb13", 1, 0, 2'b00, 0, 32'd13, 0, 2'b10, 0, 0, 32'h00000001, 0);
        issue("lh14", 1, 0, 2'b01, 0, 32'd14, 0, 2'b10, 0, 0, 32'h00000000, 0);

        issue("sb25", 0, 1, 2'b00, 0, 32'd25, 32'h000000AB, 2'b10, 1, 32'h0000AB07, 32'h0, 0);
        chk("sb25 mem6", mem[6], 32'h0000AB07);
        issue("lw24", 1, 0, 2'b10, 0, 32'd24, 0, 2'b10, 0, 0, 32'h0000AB07, 0);

        issue("sw8", 0, 1, 2'b10, 0, 32'd8, 32'h80FF0001, 2'b01, 0, 32'h80FF0001, 32'h0, 0);
        issue("lb11", 1, 0, 2'b00, 0, 32'd11, 0, 2'b10, 0, 0, 32'hFFFFFF80, 0);
        issue("lbu11", 1, 0, 2'b00, 1, 32'd11, 0, 2'b10, 0, 0, 32'h00000080, 0);
        issue("lh8", 1, 0, 2'b01, 0, 32'd8, 0, 2'b10, 0, 0, 32'h00000001, 0);
        issue("lhu10", 1, 0, 2'b01, 1, 32'd10, 0, 2'b10, 0, 0, 32'h000080FF, 0);

        issue("sh2", 0, 1, 2'b01, 0, 32'd2, 32'h1234BEEF, 2'b10, 1, 32'hBEEF1234, 32'h0, 0);
        issue("lhu2", 1, 0, 2'b01, 1, 32'd2, 0, 2'b10, 0, 0, 32'h0000BEEF, 0);
        issue("lh2", 1, 0, 2'b01, 0, 32'd2, 0, 2'b10, 0, 0, 32'hFFFFBEEF, 0);

        issue("lw40 range", 1, 0, 2'b10, 0, 32'd40, 0, 2'b00, 0, 0, 32'h0, 1);
        issue("size11", 1, 0, 2'b11, 0, 32'd0, 0, 2'b00, 0, 0, 32'h0, 1);
        issue("rd+wr", 1, 1, 2'b10, 0, 32'd0, 32'hDEADBEEF, 2'b00, 0, 0, 32'h0, 1);
        chk("rd+wr mem0", mem[0], 32'hBEEF1234);

`ifdef MISALIGN_TRAP_EN
        issue("lh13 trap", 1, 0, 2'b01, 0, 32'd13, 0, 2'b00, 0, 0, 32'h0, 1);
`else
        issue("lh13 trunc", 1, 0, 2'b01, 0, 32'd13, 0, 2'b10, 0, 0, 32'h00000104, 0);
`endif

        // reset asserted in the RMW_WRITE cycle of SH addr 4
        @(posedge clk); #1;
        in_valid = 1'b1; in_mem_write = 1'b1; in_size = 2'b01; in_unsigned = 1'b0;
        in_byte_addr = 32'd4; in_store_data = 32'h00005555;
        #1;
        chk("rstrmw rd rw", 32'(mem_read_write), 32'(2'b10));
        chk("rstrmw rd stall", 32'(stall), 32'(1'b1));
        wr_before = wr_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstrmw rw", 32'(mem_read_write), 32'(2'b00));
        chk("rstrmw stall", 32'(stall), 32'(1'b0));
        chk("rstrmw out_valid", 32'(out_valid), 32'(1'b0));
        chk("rstrmw load", out_load_data, 32'h0);
        chk("rstrmw error", 32'(out_error), 32'(1'b0));
        @(posedge clk); #1;
        chk("rstrmw no write", 32'(wr_cnt), 32'(wr_before));
        chk("rstrmw mem1", mem[1], 32'h11223344);
        chk("rstrmw out_valid2", 32'(out_valid), 32'(1'b0));
        in_valid = 1'b0; in_mem_write = 1'b0;
        rst = 1'b1;

        issue("lw4 post", 1, 0, 2'b10, 0, 32'd4, 0, 2'b10, 0, 0, 32'h11223344, 0);
        @(posedge clk); #1;
        chk("idle out_valid", 32'(out_valid), 32'(1'b0));
        chk("scoreboard drained", 32'(sb_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
